mod_n_serial_detector: RTL and testbench
========================================

Name: mod_n_serial_detector

Overview:
Parametrised serial divisibility detector. It consumes one bit per accepted cycle, either LSB-first or MSB-first, and tracks the running value modulo DIVISOR. It flags when that value is divisible and exposes the residue and a bit count. It generalises the fixed divide-by-3 serial FSM and sits on serial datapaths as a checksum/divisibility monitor.

Parameters:
DIVISOR, 3, modulus N; legal range 2..65535.
REM_W, 2, residue width; must equal ceil(log2(DIVISOR)).
LSB_FIRST, 1, 1 = first bit received has weight 2^0; 0 = first bit is the MSB (Horner form).
CNT_W, 8, width of the saturating accepted-bit counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
inp  input  1  serial data bit.
in_valid  input  1  inp is consumed on a rising edge only when high.
clear  input  1  synchronous frame restart (active-high).
out  output  1  1 when residue == 0.
remainder  output  REM_W  current value mod DIVISOR.
bit_count  output  CNT_W  bits accepted since reset/clear; saturates.

Behaviour:
- All state is registered. Outputs are driven from registers or decoded combinationally from them, with no path from inp.
- Reset (reset==0 at an edge): rem=0, weight=1, bit_count=0. Therefore out=1 (empty stream = 0). Reset has priority over everything and aborts a stream at any point.
- Accept (in_valid=1, clear=0). Latency is 1 cycle: outputs reflect all bits accepted up to and including the previous edge.
  - LSB_FIRST=1: rem' = (rem + inp*weight) mod N; weight' = (2*weight) mod N.
  - LSB_FIRST=0: rem' = (2*rem + inp) mod N; weight is unused.
  - Arithmetic: operands are < N, so intermediates are < 2N and fit in REM_W+1 bits. Reduce with a single conditional subtract of N; no divider.
  - bit_count' = bit_count+1, holding at 2^CNT_W-1 once reached. The residue keeps updating after saturation.
- Idle (in_valid=0, clear=0): all state holds.
- clear=1, in_valid=0: rem=0, weight=1, bit_count=0.
- clear=1, in_valid=1: the frame restarts and inp is the first bit of the new frame. State becomes rem=inp mod N, weight=2 mod N, bit_count=1.
- The state is equivalent to a DIVISOR-state residue FSM, plus the weight register in LSB-first mode. Every residue value 0..N-1 is reachable; no illegal-state recovery is needed.
- inp is ignored whenever in_valid=0, including when it is X.

Optional Feature:
Macro FRAME_DONE_EN.
- Defined:
  - Adds parameter FRAME_LEN (default 16, range 1..2^CNT_W-1) and outputs frame_done (1 bit) and frame_div (1 bit).
  - When the accepted bit brings the count to FRAME_LEN, frame_done pulses high for exactly the following cycle.
  - On that same edge, frame_div latches the divisibility of the completed frame, and the core auto-clears (rem=0, weight=1, bit_count=0), so the next accepted bit starts a new frame.
  - frame_div holds until the next frame completes. Reset value is frame_done=0, frame_div=1.
  - An explicit clear aborts the partial frame without pulsing frame_done.
- Undefined: none of these ports or that logic exist; the counter only saturates.

Test Plan:
1. DIVISOR=3, LSB_FIRST=1: reset low 1 edge, then feed 16'b0011100010111000 LSB-first (0x38B8=14520) -> after 16th bit out=1, remainder=0, bit_count=16; after first three bits (0,0,0) out=1; after 4th bit (1, value 8) remainder=2, out=0.
2. DIVISOR=5, LSB_FIRST=0: feed 1,1,0,1 (13) -> remainder=3, out=0; then 0 (26) -> remainder=1; then 0 (52) -> remainder=2.
3. DIVISOR=7, LSB_FIRST=1: feed 1,0,0,0,1,1 (49) -> remainder=0, out=1; after the first bit remainder=1. Interleave in_valid=0 cycles with inp toggling -> no change.
4. Clear/reset: mid-stream with remainder=2, pulse clear with in_valid=1, inp=1 -> next cycle remainder=1, bit_count=1. Drive reset=0 mid-stream -> remainder=0, out=1, bit_count=0 regardless of in_valid/clear.
5. CNT_W=4: feed 20 zero bits -> bit_count stops at 15, out stays 1. Feed one more 1 bit -> remainder is updated using the correct weight 2^20 mod N.
6. FRAME_DONE_EN, FRAME_LEN=16, DIVISOR=3: feed 0x38B8 LSB-first -> frame_done high for one cycle after the 16th bit, frame_div=1, remainder=0, bit_count=0. A following frame of 0x0001 -> frame_div=0 at its completion.

Source files
------------

// File: rtl/mod_n_serial_detector.sv
// mod_n_serial_detector: serial divisibility monitor.
// Consumes one bit per accepted cycle, either LSB-first or MSB-first (Horner form).
// It tracks the running value modulo DIVISOR and flags when the residue is zero.
// Optional framing is enabled by defining the macro FRAME_DONE_EN. This adds the
// FRAME_LEN parameter and the frame_done/frame_div outputs, and the core clears
// itself automatically at every frame boundary.
module mod_n_serial_detector #(
    parameter int DIVISOR   = 3,
    parameter int REM_W     = 2,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 8
`ifdef FRAME_DONE_EN
   ,parameter int FRAME_LEN = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inp,
    input  logic             in_valid,
    input  logic             clear,
    output logic             out,
    output logic [REM_W-1:0] remainder,
    output logic [CNT_W-1:0] bit_count
`ifdef FRAME_DONE_EN
   ,output logic             frame_done,
    output logic             frame_div
`endif
);

    // Modulus widened by one bit. Every pre-reduction sum is below 2N.
    localparam logic [REM_W:0]   N     = DIVISOR[REM_W:0];
    localparam logic [REM_W-1:0] W_ONE = {{(REM_W-1){1'b0}}, 1'b1};
`ifdef FRAME_DONE_EN
    localparam logic [CNT_W-1:0] FLEN  = FRAME_LEN[CNT_W-1:0];
`endif

    logic [REM_W-1:0] rem_q, rem_d;
    logic [REM_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REM_W-1:0] base_rem, base_w, acc_rem;
    logic [CNT_W-1:0] base_cnt, cnt_inc;
    logic [REM_W:0]   sum, w2;
    logic             frame_hit;

    // An operand below 2N needs at most one subtraction of N to reduce it.
    function automatic logic [REM_W-1:0] red(input logic [REM_W:0] x);
        logic [REM_W:0] t;
        t = (x >= N) ? x - N : x;
        return t[REM_W-1:0];
    endfunction

    // Compute the next state. When clear is high, the current state is first
    // replaced by the empty-frame state. The accepted bit (if any) is then folded
    // in, so clear together with in_valid makes inp the first bit of the new frame.
    always_comb begin
        base_rem  = clear ? '0    : rem_q;
        base_w    = clear ? W_ONE : w_q;
        base_cnt  = clear ? '0    : cnt_q;
        if (LSB_FIRST != 0)
            sum = {1'b0, base_rem} + (inp ? {1'b0, base_w} : '0);
        else
            sum = {base_rem, inp};
        w2        = {base_w, 1'b0};
        acc_rem   = red(sum);
        cnt_inc   = (base_cnt == '1) ? base_cnt : base_cnt + 1'b1;
        frame_hit = 1'b0;
        rem_d     = base_rem;
        w_d       = base_w;
        cnt_d     = base_cnt;
        if (in_valid) begin
            rem_d = acc_rem;
            w_d   = red(w2);
            cnt_d = cnt_inc;
`ifdef FRAME_DONE_EN
            // On the bit that completes a frame, fall back to the empty-frame state.
            if (cnt_inc == FLEN) begin
                frame_hit = 1'b1;
                rem_d     = '0;
                w_d       = W_ONE;
                cnt_d     = '0;
            end
`endif
        end
    end

    // State registers with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q <= '0;
            w_q   <= W_ONE;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef FRAME_DONE_EN
    // frame_done pulses for one cycle. frame_div keeps the verdict of the last
    // completed frame until the next frame completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_done <= 1'b0;
            frame_div  <= 1'b1;
        end else begin
            frame_done <= frame_hit;
            if (frame_hit) frame_div <= (acc_rem == '0);
        end
    end
`else
    // Without framing, frame_hit is tied low and has no effect.
    logic unused_frame;
    assign unused_frame = frame_hit;
`endif

    assign out       = (rem_q == '0);
    assign remainder = rem_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_mod_n_serial_detector.sv
// Directed bench for mod_n_serial_detector. It runs several configurations that
// share one stimulus bus, and checks hand-computed expected values.
module tb_mod_n_serial_detector;

    logic clk = 1'b0;
    logic reset, inp, in_valid, clear;
    int   tests = 0;
    int   fails = 0;

    logic       out3, out5, out7;
    logic [1:0] rem3;
    logic [2:0] rem5, rem7;
    logic [7:0] cnt3, cnt5;
    logic [3:0] cnt7;
`ifdef FRAME_DONE_EN
    logic       fd3, fv3, fd5, fv5, fd7, fv7, fdf, fvf, outf;
    logic [1:0] remf;
    logic [7:0] cntf;
`endif

    always #5 clk = ~clk;

    mod_n_serial_detector #(.DIVISOR(3), .REM_W(2), .LSB_FIRST(1), .CNT_W(8)
`ifdef FRAME_DONE_EN
        , .FRAME_LEN(255)
`endif
    ) d3 (.clk(clk), .reset(reset), .inp(inp), .in_valid(in_valid), .clear(clear),
          .out(out3), .remainder(rem3), .bit_count(cnt3)
`ifdef FRAME_DONE_EN
        , .frame_done(fd3), .frame_div(fv3)
`endif
    );

    mod_n_serial_detector #(.DIVISOR(5), .REM_W(3), .LSB_FIRST(0), .CNT_W(8)
`ifdef FRAME_DONE_EN
        , .FRAME_LEN(255)
`endif
    ) d5 (.clk(clk), .reset(reset), .inp(inp), .in_valid(in_valid), .clear(clear),
          .out(out5), .remainder(rem5), .bit_count(cnt5)
`ifdef FRAME_DONE_EN
        , .frame_done(fd5), .frame_div(fv5)
`endif
    );

    mod_n_serial_detector #(.DIVISOR(7), .REM_W(3), .LSB_FIRST(1), .CNT_W(4)
`ifdef FRAME_DONE_EN
        , .FRAME_LEN(15)
`endif
    ) d7 (.clk(clk), .reset(reset), .inp(inp), .in_valid(in_valid), .clear(clear),
          .out(out7), .remainder(rem7), .bit_count(cnt7)
`ifdef FRAME_DONE_EN
        , .frame_done(fd7), .frame_div(fv7)
`endif
    );

`ifdef FRAME_DONE_EN
    mod_n_serial_detector #(.DIVISOR(3), .REM_W(2), .LSB_FIRST(1), .CNT_W(8),
                            .FRAME_LEN(16))
    d3f (.clk(clk), .reset(reset), .inp(inp), .in_valid(in_valid), .clear(clear),
         .out(outf), .remainder(remf), .bit_count(cntf),
         .frame_done(fdf), .frame_div(fvf));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic b, input logic c);
        in_valid = v;
        inp      = b;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic b);
        cyc(1'b1, b, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        reset = 1'b1; inp = 1'b0; in_valid = 1'b0; clear = 1'b0;
        #2;
        do_reset();
        chk("rst_out3", out3, 1);
        chk("rst_rem3", rem3, 0);
        chk("rst_cnt3", cnt3, 0);
        chk("rst_out5", out5, 1);
        chk("rst_cnt7", cnt7, 0);

        // Mod 3, LSB-first, 0x38B8 = 14520.
        v = 16'h38B8;
        for (int i = 0; i < 16; i++) begin
            feed(v[i]);
            if (i == 2) chk("t1_out_3bits", out3, 1);
            if (i == 3) begin
                chk("t1_rem_4bits", rem3, 2);
                chk("t1_out_4bits", out3, 0);
            end
        end
        chk("t1_out_end", out3, 1);
        chk("t1_rem_end", rem3, 0);
        chk("t1_cnt_end", cnt3, 16);

        // Mod 5, MSB-first: 13, 26, 52.
        do_reset();
        feed(1); feed(1); feed(0); feed(1);
        chk("t2_rem13", rem5, 3);
        chk("t2_out13", out5, 0);
        feed(0);
        chk("t2_rem26", rem5, 1);
        feed(0);
        chk("t2_rem52", rem5, 2);
        chk("t2_cnt", cnt5, 6);

        // Mod 7, LSB-first, 49, with idle cycles while inp toggles.
        do_reset();
        feed(1);
        chk("t3_rem_first", rem7, 1);
        feed(0); feed(0);
        cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b1, 1'b0);
        chk("t3_idle_rem", rem7, 1);
        chk("t3_idle_cnt", cnt7, 3);
        feed(0); feed(1); feed(1);
        chk("t3_rem49", rem7, 0);
        chk("t3_out49", out7, 1);
        chk("t3_cnt", cnt7, 6);

        // Clear with data, clear alone, then reset mid-stream.
        do_reset();
        feed(0); feed(0); feed(0); feed(1);
        chk("t4_rem_pre", rem3, 2);
        cyc(1'b1, 1'b1, 1'b1);
        chk("t4_clrv_rem", rem3, 1);
        chk("t4_clrv_cnt", cnt3, 1);
        feed(1);
        chk("t4_clrv_w2", rem3, 0);
        chk("t4_clrv_cnt2", cnt3, 2);
        cyc(1'b0, 1'b1, 1'b1);
        chk("t4_clr_rem", rem3, 0);
        chk("t4_clr_cnt", cnt3, 0);
        feed(1); feed(1); feed(1);
        chk("t4_after_clr_rem", rem3, 1);
        chk("t4_after_clr_cnt", cnt3, 3);
        reset = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        chk("t4_rst_rem", rem3, 0);
        chk("t4_rst_out", out3, 1);
        chk("t4_rst_cnt", cnt3, 0);
        chk("t4_rst_rem5", rem5, 0);

`ifndef FRAME_DONE_EN
        // The 4-bit counter saturates, and the weight keeps advancing (2^20 mod 7 = 4).
        do_reset();
        for (int i = 0; i < 20; i++) begin
            feed(0);
            if (i == 14) chk("t5_cnt15", cnt7, 15);
        end
        chk("t5_cnt_sat", cnt7, 15);
        chk("t5_out_sat", out7, 1);
        feed(1);
        chk("t5_rem_w20", rem7, 4);
        chk("t5_cnt_hold", cnt7, 15);
        chk("t5_out_w20", out7, 0);
`else
        // Framing with 16-bit frames, mod 3.
        do_reset();
        chk("t6_rst_fd", fdf, 0);
        chk("t6_rst_fv", fvf, 1);
        v = 16'h38B8;
        for (int i = 0; i < 16; i++) feed(v[i]);
        chk("t6_fd1", fdf, 1);
        chk("t6_fv1", fvf, 1);
        chk("t6_rem1", remf, 0);
        chk("t6_cnt1", cntf, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_fd_pulse", fdf, 0);
        chk("t6_fv_hold", fvf, 1);
        v = 16'h0001;
        for (int i = 0; i < 16; i++) feed(v[i]);
        chk("t6_fd2", fdf, 1);
        chk("t6_fv2", fvf, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_fd2_off", fdf, 0);
        chk("t6_fv2_hold", fvf, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
